timer_irq: RTL and testbench



---
 rtl/timer_irq.sv | 127 ++++++++++++
 tb/tb_timer_irq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - programmable countdown timer with one-shot/auto-reload interrupt
module timer_irq #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        sticky;

  logic        enable;
  logic        auto_reload;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        oneshot_done;
  logic        count_low;

  assign enable      = ctrl[0];
  // Only mode 1 reloads; modes 0, 2 and 3 are all one-shot.
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign wr_ctrl     = we && (addr == ADDR_W'(0));
  assign wr_preset   = we && (addr == ADDR_W'(1));
  assign count_low   = (count <= 32'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and the one-shot completion strobe.
  always_comb begin
    state_n      = state;
    oneshot_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_n = S_LOAD;
      end
      S_LOAD: begin
        state_n = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (count_low) begin
          state_n = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          state_n = S_LOAD;
        end else begin
          state_n      = S_IDLE;
          oneshot_done = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Register file and counter; a CPU write in the INT cycle overrides the
  // hardware update of ctrl and keeps sticky clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      sticky <= 1'b0;
    end else begin
      if (state == S_LOAD) begin
        count <= preset;
      end else if (state == S_CNT && enable) begin
        count <= count_low ? 32'd0 : count - 32'd1;
      end

      if (wr_ctrl) begin
        ctrl <= din[3:0];
      end else if (oneshot_done) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_preset) begin
        preset <= din;
      end

      if (wr_ctrl || wr_preset) begin
        sticky <= 1'b0;
      end else if (oneshot_done) begin
        sticky <= 1'b1;
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_W'(0): dout = {28'd0, ctrl};
      ADDR_W'(1): dout = preset;
      ADDR_W'(2): dout = count;
      default:    dout = 32'd0;
    endcase
  end

  assign irq = ctrl[3] && ((state == S_INT) || sticky);

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - scoreboard testbench for timer_irq
module tb_timer_irq;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic        chk;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic        i;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;

  logic [31:0] s1c [0:6];
  logic [31:0] s2c [0:15];
  logic        s2i [0:15];
  logic [31:0] s3c [0:7];
  logic [31:0] s4a [0:5];
  logic [31:0] s4b [0:3];
  logic [31:0] s5c [0:5];

  timer_irq #(.ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the expected response whenever the stimulus flags a read.
  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        e_m = sb.pop_front();
        checks++;
        if (dout !== e_m.d) begin
          failures++;
          $display("FAIL dout tag=%0d addr=%0d got=%h expected=%h", e_m.tag, e_m.a, dout, e_m.d);
        end
        checks++;
        if (irq !== e_m.i) begin
          failures++;
          $display("FAIL irq tag=%0d got=%b expected=%b", e_m.tag, irq, e_m.i);
        end
      end
    end
  end

  // One clock cycle: drive bus, optionally queue an expected read, commit at the edge.
  task automatic c(input logic [1:0] a, input logic w, input logic [31:0] d,
                   input bit ck, input logic [31:0] ed, input logic ei, input int tag);
    exp_t e;
    addr = a;
    we   = w;
    din  = d;
    if (ck) begin
      e.a   = a;
      e.d   = ed;
      e.i   = ei;
      e.tag = tag;
      sb.push_back(e);
      chk = 1'b1;
    end else begin
      chk = 1'b0;
    end
    @(posedge clk);
    #1;
    we  = 1'b0;
    chk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) c(2'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    addr     = 2'd0;
    we       = 1'b0;
    din      = 32'd0;
    chk      = 1'b0;

    s1c = '{0, 0, 5, 4, 3, 2, 1};
    s2c = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0};
    s2i = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    s3c = '{3, 3, 5, 4, 3, 2, 1, 0};
    s4a = '{0, 0, 10, 9, 8, 7};
    s4b = '{5, 5, 10, 9};
    s5c = '{7, 7, 4, 3, 2, 1};

    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1);
    c(2'd1, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 2);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 3);
    c(2'd3, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 4);

    // One-shot, IM=1, preset 5: INT seven cycles after the enable write, sticky irq.
    c(2'd1, 1'b1, 32'd5, 1'b1, 32'd0, 1'b0, 100);
    c(2'd0, 1'b1, 32'h9, 1'b1, 32'd0, 1'b0, 101);
    for (int k = 0; k < 7; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s1c[k], 1'b0, 110 + k);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h9, 1'b1, 120);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b1, 121);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1, 122);
    c(2'd0, 1'b1, 32'h8, 1'b1, 32'h8, 1'b1, 123);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b0, 124);

    // Auto-reload, preset 3: one-cycle pulse every 5 cycles, Enable kept.
    c(2'd1, 1'b1, 32'd3, 1'b1, 32'd5, 1'b0, 200);
    c(2'd0, 1'b1, 32'hB, 1'b1, 32'h8, 1'b0, 201);
    for (int k = 0; k < 16; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s2c[k], s2i[k], 210 + k);
    c(2'd0, 1'b1, 32'h0, 1'b1, 32'hB, 1'b0, 230);
    idle(2);

    // One-shot with IM=0: irq never asserts.
    c(2'd1, 1'b1, 32'd5, 1'b1, 32'd3, 1'b0, 300);
    c(2'd0, 1'b1, 32'h1, 1'b0, 32'd0, 1'b0, 301);
    for (int k = 0; k < 8; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s3c[k], 1'b0, 310 + k);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, 320);
    c(2'd0, 1'b1, 32'h8, 1'b1, 32'h0, 1'b0, 321);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b0, 322);

    // Disable mid-count freezes COUNT; re-enable reloads from preset.
    c(2'd1, 1'b1, 32'd10, 1'b1, 32'd5, 1'b0, 400);
    c(2'd0, 1'b1, 32'h9, 1'b0, 32'd0, 1'b0, 401);
    for (int k = 0; k < 6; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s4a[k], 1'b0, 410 + k);
    c(2'd0, 1'b1, 32'h8, 1'b1, 32'h9, 1'b0, 420);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd5, 1'b0, 421);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd5, 1'b0, 422);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd5, 1'b0, 423);
    c(2'd0, 1'b1, 32'h9, 1'b1, 32'h8, 1'b0, 424);
    for (int k = 0; k < 4; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s4b[k], 1'b0, 430 + k);
    c(2'd0, 1'b1, 32'h0, 1'b1, 32'h9, 1'b0, 440);
    idle(2);

    // CTRL write in the INT cycle wins: sticky stays 0, timer restarts.
    c(2'd1, 1'b1, 32'd4, 1'b1, 32'd10, 1'b0, 500);
    c(2'd0, 1'b1, 32'h9, 1'b0, 32'd0, 1'b0, 501);
    for (int k = 0; k < 6; k++) c(2'd2, 1'b0, 32'd0, 1'b1, s5c[k], 1'b0, 510 + k);
    c(2'd0, 1'b1, 32'h9, 1'b1, 32'h9, 1'b1, 520);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h9, 1'b0, 521);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 522);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd4, 1'b0, 523);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 524);

    // COUNT is read-only; reset mid-count clears everything.
    c(2'd2, 1'b1, 32'h1234, 1'b1, 32'd2, 1'b0, 600);
    reset = 1'b1;
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 601);
    reset = 1'b0;
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 602);
    c(2'd1, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 603);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 604);
    c(2'd3, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 605);

    // Preset 0 behaves as 1; a PRESET write clears sticky.
    c(2'd1, 1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 700);
    c(2'd0, 1'b1, 32'h9, 1'b0, 32'd0, 1'b0, 701);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 710);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 711);
    c(2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 712);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h9, 1'b1, 713);
    c(2'd0, 1'b0, 32'd0, 1'b1, 32'h8, 1'b1, 714);
    c(2'd1, 1'b1, 32'd7, 1'b1, 32'd0, 1'b1, 715);
    c(2'd1, 1'b0, 32'd0, 1'b1, 32'd7, 1'b0, 716);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
